// File: rtl/conv_pkg.sv
// Shared parameters and helpers for the convolution cores (full, depthwise, pointwise).
// Holds default widths, the accumulator-width rule and the round/saturate bounds.
package conv_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_FRAC_W = 5;
    localparam int DEF_KSIZE  = 9;

    // Wide enough that a full window of products plus the aligned bias can never overflow.
    function automatic int acc_width(input int data_w, input int ksize);
        return 2 * data_w + $clog2(ksize) + 1;
    endfunction

    function automatic int sat_hi(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int data_w);
        return -(1 << (data_w - 1));
    endfunction

    localparam int SAT_HI = sat_hi(DEF_DATA_W);
    localparam int SAT_LO = sat_lo(DEF_DATA_W);

endpackage

// File: rtl/conv_round_sat.sv
// Combinational round-half-up, saturate and optional ReLU from accumulator to activation width.
// Optional feature: CONV_RELU_EN forces negative results to zero after saturation.
module conv_round_sat
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_KSIZE)
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] result,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] HI   = ACC_W'(sat_hi(DATA_W));
    localparam logic signed [ACC_W-1:0] LO   = ACC_W'(sat_lo(DATA_W));
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC_W - 1));

    logic signed [ACC_W-1:0] rounded;

    always_comb begin
        rounded = (acc + HALF) >>> FRAC_W;
        sat     = 1'b0;
        result  = rounded[DATA_W-1:0];
        if (rounded > HI) begin
            result = HI[DATA_W-1:0];
            sat    = 1'b1;
        end else if (rounded < LO) begin
            result = LO[DATA_W-1:0];
            sat    = 1'b1;
        end
`ifdef CONV_RELU_EN
        // sat keeps reporting the clip that happened before the ReLU
        if (result[DATA_W-1]) begin
            result = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/conv_core_pipe.sv
// Four-stage pipelined KSIZE-tap convolution core with weight bank and valid/ready streaming.
// Optional feature: CONV_RELU_EN (see conv_round_sat) clamps negative results to zero.
module conv_core_pipe
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int KSIZE  = DEF_KSIZE
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [KSIZE*DATA_W-1:0]   i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [KSIZE*DATA_W-1:0]   i_weight,
    input  logic [DATA_W-1:0]         i_bias,
    input  logic                      i_weight_we,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_sat,
    output logic                      o_valid,
    input  logic                      i_ready
);

    localparam int ACC_W = acc_width(DATA_W, KSIZE);
    localparam int P_W   = 2 * DATA_W;
    localparam int NGRP  = (KSIZE + 2) / 3;

    logic signed [DATA_W-1:0] w_bank [KSIZE];
    logic signed [DATA_W-1:0] bias_q;

    logic signed [P_W-1:0]    prod_d [KSIZE];
    logic signed [P_W-1:0]    prod_q [KSIZE];
    logic signed [ACC_W-1:0]  psum_d [NGRP];
    logic signed [ACC_W-1:0]  psum_q [NGRP];
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  sum_q;
    logic signed [DATA_W-1:0] s1_bias;
    logic signed [DATA_W-1:0] s2_bias;
    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s3_valid;

    logic signed [DATA_W-1:0] rs_data;
    logic                     rs_sat;
    logic                     stall;

    assign stall   = o_valid && !i_ready;
    assign o_ready = !stall;

    // The bank loads independently of stall; a beat accepted on the write edge sees the old set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < KSIZE; k++) begin
                w_bank[k] <= '0;
            end
            bias_q <= '0;
        end else if (i_weight_we) begin
            for (int k = 0; k < KSIZE; k++) begin
                w_bank[k] <= i_weight[k*DATA_W +: DATA_W];
            end
            bias_q <= i_bias;
        end
    end

    always_comb begin
        for (int k = 0; k < KSIZE; k++) begin
            prod_d[k] = P_W'(signed'(i_data[k*DATA_W +: DATA_W])) * P_W'(w_bank[k]);
        end
    end

    always_comb begin
        for (int g = 0; g < NGRP; g++) begin
            psum_d[g] = '0;
            for (int j = 0; j < 3; j++) begin
                if (g * 3 + j < KSIZE) begin
                    psum_d[g] = psum_d[g] + ACC_W'(prod_q[g*3+j]);
                end
            end
        end
    end

    // Bias travels with its beat so a bank write never touches beats already in flight.
    always_comb begin
        sum_d = ACC_W'(s2_bias) <<< FRAC_W;
        for (int g = 0; g < NGRP; g++) begin
            sum_d = sum_d + psum_q[g];
        end
    end

    conv_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_round_sat (
        .acc    (sum_q),
        .result (rs_data),
        .sat    (rs_sat)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < KSIZE; k++) begin
                prod_q[k] <= '0;
            end
            for (int g = 0; g < NGRP; g++) begin
                psum_q[g] <= '0;
            end
            s1_bias  <= '0;
            s2_bias  <= '0;
            sum_q    <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_sat    <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < KSIZE; k++) begin
                prod_q[k] <= prod_d[k];
            end
            for (int g = 0; g < NGRP; g++) begin
                psum_q[g] <= psum_d[g];
            end
            s1_bias  <= bias_q;
            s2_bias  <= s1_bias;
            sum_q    <= sum_d;
            s1_valid <= i_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            o_valid  <= s3_valid;
            if (s3_valid) begin
                o_data <= rs_data;
                o_sat  <= rs_sat;
            end
        end
    end

endmodule
